// File: rtl/dp_sched.sv
// ============================================================================
// dp_sched : picks the two highest-priority requests; fixed or round-robin order
// Revision : 1.0
// ============================================================================
`default_nettype none

module dp_sched #(
    parameter int N      = 12,
    parameter int IDXW   = 4,
    parameter int ROTATE = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IDXW-1:0] first,
    output logic [IDXW-1:0] second
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [PW-1:0] c_ptr_rst = PW'(N - 1);
    localparam logic [PW-1:0] c_ptr_one = PW'(1);
    localparam logic [IDXW-1:0] c_idx_one = IDXW'(1);

    logic            out_valid_q, out_valid_d;
    logic [IDXW-1:0] first_q, first_d;
    logic [IDXW-1:0] second_q, second_d;
    logic [PW-1:0]   ptr_q, ptr_d;

    logic            accept;
    logic            deliver;
    logic            hit0, hit1;
    logic [PW-1:0]   g0, g1;
    logic [PW-1:0]   pos;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid_q && out_ready;

    // Walk positions ptr, ptr-1, ... wrapping at 0; fixed mode keeps ptr at N-1.
    always_comb begin
        hit0 = 1'b0;
        hit1 = 1'b0;
        g0   = '0;
        g1   = '0;
        pos  = '0;
        for (int k = 0; k < N; k++) begin
            if (k <= int'(ptr_q)) begin
                pos = PW'(int'(ptr_q) - k);
            end else begin
                pos = PW'(int'(ptr_q) + N - k);
            end
            if (req[pos]) begin
                if (!hit0) begin
                    hit0 = 1'b1;
                    g0   = pos;
                end else if (!hit1) begin
                    hit1 = 1'b1;
                    g1   = pos;
                end
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        first_d     = first_q;
        second_d    = second_q;
        ptr_d       = ptr_q;
        if (accept) begin
            out_valid_d = 1'b1;
            first_d     = hit0 ? (IDXW'(g0) + c_idx_one) : '0;
            second_d    = hit1 ? (IDXW'(g1) + c_idx_one) : '0;
            if ((ROTATE != 0) && hit0) begin
                ptr_d = (g0 == '0) ? c_ptr_rst : (g0 - c_ptr_one);
            end
        end else if (deliver) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            first_q     <= '0;
            second_q    <= '0;
            ptr_q       <= c_ptr_rst;
        end else begin
            out_valid_q <= out_valid_d;
            first_q     <= first_d;
            second_q    <= second_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign first     = first_q;
    assign second    = second_q;

endmodule

`default_nettype wire

// File: doc/dp_sched.md
DP_SCHED -- requirements
Module: dp_sched

Interface
REQ-001 The block SHALL have parameter N, default 12, giving the number of request lines (legal range 2..255).
REQ-002 The block SHALL have parameter IDXW, default 4, giving the index output width; it SHALL be at least ceil(log2(N+1)).
REQ-003 The block SHALL have parameter ROTATE, default 0, selecting priority mode: 0 = fixed, 1 = round-robin.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 The block SHALL have port req, input, N bits: request vector, bit i = requester i.
REQ-007 The block SHALL have port in_valid, input, 1 bit: req is valid this cycle.
REQ-008 The block SHALL have port in_ready, output, 1 bit: the block accepts req this cycle.
REQ-009 The block SHALL have port out_valid, output, 1 bit: first and second hold a result.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result this cycle.
REQ-011 The block SHALL have port first, output, IDXW bits: 1-based index of the highest-priority set bit; 0 = none.
REQ-012 The block SHALL have port second, output, IDXW bits: 1-based index of the second-highest-priority set bit; 0 = none.

Function
REQ-013 A request SHALL be accepted on a clk edge where in_valid=1 and in_ready=1.
REQ-014 A result SHALL be delivered on a clk edge where out_valid=1 and out_ready=1.
REQ-015 in_ready SHALL equal (!out_valid || out_ready), combinationally; there is no other input buffering.
REQ-016 Latency SHALL be one cycle: out_valid is 1 in the cycle after an accept, with first and second registered.
REQ-017 Throughput SHALL be one result per cycle: on a simultaneous deliver and accept, the new result replaces the old on the same edge.
REQ-018 While out_valid=1 and out_ready=0, first, second and out_valid SHALL hold stable.
REQ-019 On a deliver with no accept, out_valid SHALL go to 0; first and second keep their last values.
REQ-020 Fixed mode: bit N-1 SHALL have highest priority, descending to bit 0.
REQ-021 Round-robin mode: a pointer ptr (0..N-1) SHALL set the priority order ptr, ptr-1, ..., 0, N-1, ..., ptr+1.
REQ-022 Round-robin mode: on accept with at least one bit set, ptr SHALL become (g-1) mod N, where g is the bit index reported as first (0-based).
- Index 0 wraps to N-1.
REQ-023 ptr SHALL be unchanged when req=0 is accepted, when nothing is accepted, and always in fixed mode.
REQ-024 When req=0, the result SHALL be first=0 and second=0.
REQ-025 When exactly one bit of req is set, the result SHALL be second=0.
REQ-026 The priority evaluation SHALL use the req value sampled at accept; req changes without an accept SHALL have no effect.
REQ-027 The design SHALL be free of combinational paths from out_ready to first or second.
- The only combinational path from out_ready is to in_ready.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force out_valid=0, first=0, second=0 and ptr=N-1.
- Round-robin order then initially equals fixed order.
REQ-029 A reset asserted mid-operation SHALL discard any pending result; no result SHALL be delivered for it.
REQ-030 in_ready SHALL be 1 during reset; no accept SHALL occur while rst_n=0.
REQ-031 Accepts SHALL be possible from the first clk edge after rst_n deasserts.

Verification (N=12, IDXW=4)
REQ-032 Fixed priority: ROTATE=0, accept req=12'hA00 -> next cycle out_valid=1, first=12, second=10.
REQ-033 Empty and single request: accept req=12'h000 -> first=0, second=0; then accept req=12'h001 -> first=1, second=0.
REQ-034 Backpressure: result pending, out_ready=0 for 2 cycles with in_valid=1 and req changing -> in_ready=0, outputs stable, no accept; out_ready=1 -> delivered, and the pending req is accepted the same edge.
REQ-035 Round-robin sweep: ROTATE=1, accept req=12'hFFF four times back-to-back -> first=12,11,10,9 and second=11,10,9,8.
REQ-036 Round-robin wrap: ROTATE=1, req=12'h801 accepted three times -> (first,second) = (12,1), (1,12), (12,1), with ptr = 10, 11, 10.
REQ-037 Reset mid-operation: rst_n low while out_valid=1 and ptr=5 -> out_valid=0, first=second=0 and ptr=11 without a clk edge; the next accept of req=12'hFFF gives first=12.
